controle_janela: RTL and testbench
==================================

CONTROLE_JANELA -- requirements
Module: controle_janela

Interface
REQ-001 The block SHALL have a parameter CICLOS_JANELA, default 50000000, giving the counting-window length in clk cycles (minimum 1).
REQ-002 The block SHALL have a parameter CICLOS_LIMPAR, default 2, giving the clear-pulse length in clk cycles (minimum 1).
REQ-003 The block SHALL have input port clk, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have input port rst_n, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have input port iniciar, 1 bit: start request, sampled only in OCIOSO.
REQ-006 The block SHALL have input port parar, 1 bit: abort request.
REQ-007 The block SHALL have input port continuo, 1 bit: when 1, measurements repeat back-to-back.
REQ-008 The block SHALL have input port amostra_in, 1 bit: raw asynchronous input signal being measured.
REQ-009 The block SHALL have output port amostra, 1 bit: amostra_in synchronised to clk, driven to the BCD counter's sample input.
REQ-010 The block SHALL have output port habilitar, 1 bit: counting window, driven to the BCD counter's enable.
REQ-011 The block SHALL have output port limpar, 1 bit: clear pulse, driven to the BCD counter's clear.
REQ-012 The block SHALL have output port travar, 1 bit: one-cycle strobe for the downstream display registers to latch the counts.
REQ-013 The block SHALL have output port pronto, 1 bit: a completed measurement is available.
REQ-014 The block SHALL have output port medidas, 8 bits: count of completed measurements.

Function
REQ-015 amostra SHALL equal amostra_in delayed through exactly two clk flip-flops.
REQ-016 The FSM SHALL have exactly the states OCIOSO, LIMPA, CONTA and TRAVA; all outputs SHALL be registered (Moore) and no output SHALL be combinational from any input.
REQ-017 In OCIOSO, iniciar=1 with parar=0 at a clk edge SHALL move the FSM to LIMPA; iniciar SHALL be ignored in every other state.
REQ-018 In LIMPA: limpar=1 and habilitar=0 for exactly CICLOS_LIMPAR cycles, then CONTA.
REQ-019 In CONTA: habilitar=1 and limpar=0 for exactly CICLOS_JANELA cycles, then TRAVA.
REQ-020 In TRAVA: travar=1 for exactly one cycle, habilitar=0, and medidas increments by 1, wrapping 255 to 0.
REQ-021 On leaving TRAVA, the FSM SHALL go to LIMPA if continuo=1, otherwise to OCIOSO with pronto=1.
REQ-022 pronto SHALL be 0 in every state except OCIOSO, and SHALL go to 0 on the cycle LIMPA is entered.
REQ-023 parar=1 in LIMPA or CONTA SHALL move the FSM to OCIOSO on the next cycle:
- habilitar and limpar drop to 0.
- travar is not pulsed.
- medidas is unchanged.
- pronto remains 0.
REQ-024 parar=1 in TRAVA SHALL not suppress the travar pulse but SHALL force the next state to OCIOSO regardless of continuo.
REQ-025 parar SHALL take priority over iniciar when both are 1 in OCIOSO (the FSM stays in OCIOSO).
REQ-026 The window and clear counters SHALL be $clog2 of their parameter (minimum width 1) and SHALL restart from 0 on every entry to their state.
REQ-027 habilitar, limpar and travar SHALL be mutually exclusive in every cycle.

Reset
REQ-028 rst_n=0 SHALL, asynchronously, force:
- state OCIOSO;
- habilitar, limpar, travar, pronto and amostra to 0;
- medidas to 0;
- both synchroniser flip-flops and all counters to 0.
REQ-029 Reset asserted mid-window SHALL drop habilitar immediately, with no travar pulse.
REQ-030 After rst_n rises, the first possible transition out of OCIOSO SHALL be on a clk edge with iniciar=1.

Verification (CICLOS_JANELA=10, CICLOS_LIMPAR=2)
REQ-031 Single shot: iniciar pulsed 1 cycle with continuo=0 -> limpar=1 for 2 cycles, habilitar=1 for 10 cycles, travar=1 for 1 cycle, then pronto=1 and medidas=1.
REQ-032 Continuous: continuo=1, 3 windows -> the sequence limpar(2)/habilitar(10)/travar(1) repeats with no gap, and medidas=3 after the third travar.
REQ-033 Abort: parar=1 at the 5th habilitar cycle -> habilitar=0 next cycle, no travar, medidas unchanged, state OCIOSO.
REQ-034 Wrap: 256 completed measurements -> medidas=0.
REQ-035 Reset mid-window: rst_n=0 at the 3rd habilitar cycle -> all outputs 0 immediately, and iniciar is required to restart.
REQ-036 Synchroniser: an amostra_in edge -> amostra follows exactly 2 clk edges later; simultaneous iniciar=1 and parar=1 in OCIOSO -> no state change.

Source files
------------

// File: rtl/controle_janela.sv
// controle_janela: sequences the clear / count / latch cycle of a BCD
// frequency counter and synchronises the measured input to clk.
// A measurement is: clear pulse (LIMPA), counting window (CONTA), latch
// strobe (TRAVA). It optionally repeats back-to-back and can be aborted at
// any time by parar.
module controle_janela #(
    parameter int CICLOS_JANELA = 50000000,
    parameter int CICLOS_LIMPAR = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       continuo,
    input  logic       amostra_in,
    output logic       amostra,
    output logic       habilitar,
    output logic       limpar,
    output logic       travar,
    output logic       pronto,
    output logic [7:0] medidas
);

    // Counter widths never drop below one bit, even for a 1-cycle phase.
    localparam int LARG_J = (CICLOS_JANELA > 1) ? $clog2(CICLOS_JANELA) : 1;
    localparam int LARG_L = (CICLOS_LIMPAR > 1) ? $clog2(CICLOS_LIMPAR) : 1;

    // Last count value of each phase; the phase ends on the edge that sees it.
    localparam logic [LARG_J-1:0] FIM_J = LARG_J'(CICLOS_JANELA - 1);
    localparam logic [LARG_L-1:0] FIM_L = LARG_L'(CICLOS_LIMPAR - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        LIMPA  = 2'd1,
        CONTA  = 2'd2,
        TRAVA  = 2'd3
    } estado_t;

    estado_t           estado_r;
    logic [LARG_J-1:0] cont_janela_r;
    logic [LARG_L-1:0] cont_limpa_r;
    logic [1:0]        sinc_r;

    assign amostra = sinc_r[1];

    // Two-flop synchroniser bringing the asynchronous input into clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc_r <= 2'b00;
        end else begin
            sinc_r <= {sinc_r[0], amostra_in};
        end
    end

    // Measurement FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r      <= OCIOSO;
            cont_janela_r <= {LARG_J{1'b0}};
            cont_limpa_r  <= {LARG_L{1'b0}};
            habilitar     <= 1'b0;
            limpar        <= 1'b0;
            travar        <= 1'b0;
            pronto        <= 1'b0;
            medidas       <= 8'd0;
        end else begin
            // travar is a single-cycle strobe, so it falls unless re-armed.
            travar <= 1'b0;
            case (estado_r)
                OCIOSO: begin
                    // parar wins over iniciar; pronto holds until a restart.
                    if (iniciar && !parar) begin
                        estado_r     <= LIMPA;
                        limpar       <= 1'b1;
                        pronto       <= 1'b0;
                        cont_limpa_r <= {LARG_L{1'b0}};
                    end else begin
                        estado_r <= OCIOSO;
                    end
                end
                LIMPA: begin
                    if (parar) begin
                        estado_r <= OCIOSO;
                        limpar   <= 1'b0;
                    end else if (cont_limpa_r == FIM_L) begin
                        estado_r      <= CONTA;
                        limpar        <= 1'b0;
                        habilitar     <= 1'b1;
                        cont_janela_r <= {LARG_J{1'b0}};
                    end else begin
                        cont_limpa_r <= cont_limpa_r + {{(LARG_L-1){1'b0}}, 1'b1};
                    end
                end
                CONTA: begin
                    if (parar) begin
                        estado_r  <= OCIOSO;
                        habilitar <= 1'b0;
                    end else if (cont_janela_r == FIM_J) begin
                        estado_r  <= TRAVA;
                        habilitar <= 1'b0;
                        travar    <= 1'b1;
                        medidas   <= medidas + 8'd1;
                    end else begin
                        cont_janela_r <= cont_janela_r + {{(LARG_J-1){1'b0}}, 1'b1};
                    end
                end
                TRAVA: begin
                    // The latch strobe is never suppressed; parar only
                    // cancels the automatic restart.
                    if (continuo && !parar) begin
                        estado_r     <= LIMPA;
                        limpar       <= 1'b1;
                        cont_limpa_r <= {LARG_L{1'b0}};
                    end else begin
                        estado_r <= OCIOSO;
                        pronto   <= 1'b1;
                    end
                end
                default: begin
                    estado_r  <= OCIOSO;
                    habilitar <= 1'b0;
                    limpar    <= 1'b0;
                    pronto    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_janela.sv
// Directed bench for controle_janela with a 10-cycle window and 2-cycle clear.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_controle_janela;

    logic       clk_1;
    logic       rst_n;
    logic       iniciar;
    logic       parar;
    logic       continuo;
    logic       amostra_in;
    logic       amostra;
    logic       habilitar;
    logic       limpar;
    logic       travar;
    logic       pronto;
    logic [7:0] medidas;

    int testes;
    int falhas;

    controle_janela #(
        .CICLOS_JANELA(10),
        .CICLOS_LIMPAR(2)
    ) dut (
        .clk       (clk_1),
        .rst_n     (rst_n),
        .iniciar   (iniciar),
        .parar     (parar),
        .continuo  (continuo),
        .amostra_in(amostra_in),
        .amostra   (amostra),
        .habilitar (habilitar),
        .limpar    (limpar),
        .travar    (travar),
        .pronto    (pronto),
        .medidas   (medidas)
    );

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    // Expected {limpar,habilitar,travar} at position 1..13 of one window.
    function automatic logic [2:0] esperado(input int pos);
        if (pos <= 2)       return 3'b100;
        else if (pos <= 12) return 3'b010;
        else                return 3'b001;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; iniciar = 1'b0; parar = 1'b0; continuo = 1'b0; amostra_in = 1'b0;
        repeat (2) @(negedge clk_1);
        testes++;
        if ({limpar, habilitar, travar, pronto, amostra} !== 5'b00000) begin
            falhas++;
            $display("FAIL reset_outputs: got %b, expected 00000", {limpar, habilitar, travar, pronto, amostra});
        end
        testes++;
        if (medidas !== 8'd0) begin
            falhas++;
            $display("FAIL reset_medidas: got %0d, expected 0", medidas);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk_1);
        testes++;
        if ({limpar, habilitar, travar} !== 3'b000) begin
            falhas++;
            $display("FAIL reset_idle: got %b, expected 000", {limpar, habilitar, travar});
        end
    endtask

    task automatic test_single_shot();
        iniciar = 1'b1; continuo = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk_1);
            iniciar = (c == 4) ? 1'b1 : 1'b0;   // pulse inside CONTA must be ignored
            testes++;
            if ({limpar, habilitar, travar} !== esperado(c)) begin
                falhas++;
                $display("FAIL single_seq c=%0d: got %b, expected %b", c, {limpar, habilitar, travar}, esperado(c));
            end
        end
        testes++;
        if (medidas !== 8'd1 || pronto !== 1'b0) begin
            falhas++;
            $display("FAIL single_trava: medidas=%0d pronto=%b, expected 1/0", medidas, pronto);
        end
        @(negedge clk_1);
        testes++;
        if ({limpar, habilitar, travar, pronto} !== 4'b0001 || medidas !== 8'd1) begin
            falhas++;
            $display("FAIL single_end: got %b medidas=%0d, expected 0001 medidas=1", {limpar, habilitar, travar, pronto}, medidas);
        end
    endtask

    task automatic test_continuo();
        iniciar = 1'b1; continuo = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk_1);
            iniciar = 1'b0;
            testes++;
            if ({limpar, habilitar, travar} !== esperado(((c - 1) % 13) + 1)) begin
                falhas++;
                $display("FAIL cont_seq c=%0d: got %b, expected %b", c, {limpar, habilitar, travar}, esperado(((c - 1) % 13) + 1));
            end
            if (c == 1) begin
                testes++;
                if (pronto !== 1'b0) begin
                    falhas++;
                    $display("FAIL cont_pronto_drop: got %b, expected 0", pronto);
                end
            end
            if (c == 13 || c == 26 || c == 39) begin
                testes++;
                if (medidas !== 8'(1 + c / 13)) begin
                    falhas++;
                    $display("FAIL cont_medidas c=%0d: got %0d, expected %0d", c, medidas, 1 + c / 13);
                end
            end
        end
        continuo = 1'b0;
        @(negedge clk_1);
        testes++;
        if ({limpar, habilitar, travar, pronto} !== 4'b0001 || medidas !== 8'd4) begin
            falhas++;
            $display("FAIL cont_end: got %b medidas=%0d, expected 0001 medidas=4", {limpar, habilitar, travar, pronto}, medidas);
        end
    endtask

    task automatic test_abort();
        iniciar = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_1);
            iniciar = 1'b0;
        end
        testes++;
        if (habilitar !== 1'b1) begin
            falhas++;
            $display("FAIL abort_pre: habilitar=%b, expected 1", habilitar);
        end
        parar = 1'b1;
        @(negedge clk_1);
        parar = 1'b0;
        testes++;
        if ({limpar, habilitar, travar, pronto} !== 4'b0000 || medidas !== 8'd4) begin
            falhas++;
            $display("FAIL abort_stop: got %b medidas=%0d, expected 0000 medidas=4", {limpar, habilitar, travar, pronto}, medidas);
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_1);
            testes++;
            if ({limpar, habilitar, travar, pronto} !== 4'b0000) begin
                falhas++;
                $display("FAIL abort_idle c=%0d: got %b, expected 0000", c, {limpar, habilitar, travar, pronto});
            end
        end
    endtask

    task automatic test_parar_trava();
        iniciar = 1'b1; continuo = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk_1);
            iniciar = 1'b0;
        end
        testes++;
        if (travar !== 1'b1 || medidas !== 8'd5) begin
            falhas++;
            $display("FAIL trava_pulse: travar=%b medidas=%0d, expected 1/5", travar, medidas);
        end
        parar = 1'b1;
        @(negedge clk_1);
        parar = 1'b0; continuo = 1'b0;
        testes++;
        if ({limpar, habilitar, travar, pronto} !== 4'b0001) begin
            falhas++;
            $display("FAIL trava_parar: got %b, expected 0001", {limpar, habilitar, travar, pronto});
        end
    endtask

    task automatic test_iniciar_parar();
        iniciar = 1'b1; parar = 1'b1;
        repeat (2) @(negedge clk_1);
        iniciar = 1'b0; parar = 1'b0;
        testes++;
        if ({limpar, habilitar, travar, pronto} !== 4'b0001) begin
            falhas++;
            $display("FAIL iniciar_parar: got %b, expected 0001", {limpar, habilitar, travar, pronto});
        end
        @(negedge clk_1);
        testes++;
        if ({limpar, habilitar, travar} !== 3'b000) begin
            falhas++;
            $display("FAIL iniciar_parar_hold: got %b, expected 000", {limpar, habilitar, travar});
        end
    endtask

    task automatic test_reset_mid();
        iniciar = 1'b1; amostra_in = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_1);
            iniciar = 1'b0;
        end
        testes++;
        if (habilitar !== 1'b1) begin
            falhas++;
            $display("FAIL rstmid_pre: habilitar=%b, expected 1", habilitar);
        end
        rst_n = 1'b0;
        #1;
        testes++;
        if ({limpar, habilitar, travar, pronto, amostra} !== 5'b00000 || medidas !== 8'd0) begin
            falhas++;
            $display("FAIL rstmid_now: got %b medidas=%0d, expected 00000 medidas=0", {limpar, habilitar, travar, pronto, amostra}, medidas);
        end
        amostra_in = 1'b0;
        @(negedge clk_1);
        rst_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_1);
            testes++;
            if ({limpar, habilitar, travar, pronto} !== 4'b0000) begin
                falhas++;
                $display("FAIL rstmid_idle c=%0d: got %b, expected 0000", c, {limpar, habilitar, travar, pronto});
            end
        end
        iniciar = 1'b1;
        @(negedge clk_1);
        iniciar = 1'b0;
        testes++;
        if ({limpar, habilitar, travar} !== 3'b100) begin
            falhas++;
            $display("FAIL rstmid_restart: got %b, expected 100", {limpar, habilitar, travar});
        end
        parar = 1'b1;
        @(negedge clk_1);
        parar = 1'b0;
    endtask

    task automatic test_wrap();
        int pulsos;
        bit fim;
        pulsos = 0; fim = 1'b0;
        iniciar = 1'b1; continuo = 1'b1;
        for (int c = 1; c <= 4000 && !fim; c++) begin
            @(negedge clk_1);
            iniciar = 1'b0;
            if (travar === 1'b1) begin
                pulsos++;
                if (pulsos == 255) begin
                    testes++;
                    if (medidas !== 8'd255) begin
                        falhas++;
                        $display("FAIL wrap_255: got %0d, expected 255", medidas);
                    end
                end
                if (pulsos == 256) begin
                    testes++;
                    if (medidas !== 8'd0) begin
                        falhas++;
                        $display("FAIL wrap_0: got %0d, expected 0", medidas);
                    end
                    continuo = 1'b0;
                    fim = 1'b1;
                end
            end
        end
        testes++;
        if (pulsos != 256) begin
            falhas++;
            $display("FAIL wrap_timeout: got %0d travar pulses, expected 256", pulsos);
        end
        @(negedge clk_1);
        testes++;
        if (pronto !== 1'b1) begin
            falhas++;
            $display("FAIL wrap_pronto: got %b, expected 1", pronto);
        end
    endtask

    task automatic test_sincronizador();
        for (int v = 1; v >= 0; v--) begin
            amostra_in = v[0];
            @(negedge clk_1);
            testes++;
            if (amostra !== ~v[0]) begin
                falhas++;
                $display("FAIL sync_1edge v=%0d: got %b, expected %b", v, amostra, ~v[0]);
            end
            @(negedge clk_1);
            testes++;
            if (amostra !== v[0]) begin
                falhas++;
                $display("FAIL sync_2edge v=%0d: got %b, expected %b", v, amostra, v[0]);
            end
        end
    endtask

    initial begin
        testes = 0;
        falhas = 0;
        test_reset();
        test_single_shot();
        test_continuo();
        test_abort();
        test_parar_trava();
        test_iniciar_parar();
        test_reset_mid();
        test_wrap();
        test_sincronizador();
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
